// File: rtl/alu_cmd_ctrl.sv
// Command framer between a UART byte stream and an ALU: parses CC (load+run) and
// DD (rerun with new function) frames, pulses one ALU execute, returns the result LSB first.
module alu_cmd_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    output logic             alu_en,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_valid,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_busy,
    output logic             frame_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [7:0] CMD_LOAD   = 8'hCC;
    localparam logic [7:0] CMD_REPEAT = 8'hDD;

    // Error result: every byte 0xEE, truncated to WIDTH
    localparam int NB = WIDTH / 8 + 1;
    localparam logic [8*NB-1:0]  EE_WIDE = {NB{8'hEE}};
    localparam logic [WIDTH-1:0] RES_ERR = EE_WIDE[WIDTH-1:0];

    typedef enum logic [2:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        EXEC,
        CAPTURE,
        SEND_LO,
        SEND_HI
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             err_nxt;
    logic [CNT_W-1:0] cnt;
    logic             in_get;
    logic             timeout;

    logic [7:0]       a_stage;
    logic [7:0]       b_stage;
    logic             cc_frame;
    logic [7:0]       op_a;
    logic [7:0]       op_b;
    logic [3:0]       fun;
    logic             alu_ok;
    logic [WIDTH-1:0] res;

    logic [WIDTH+15:0] res_ext;
    logic              unused_res_hi;

    assign in_get  = (state == GET_A) || (state == GET_B) || (state == GET_FUN);
    assign timeout = (cnt == CNT_W'(TIMEOUT - 1));

    // Only the low 16 result bits go out on the wire; narrower results are zero-padded
    assign res_ext       = {16'h0000, res};
    assign unused_res_hi = |res_ext[WIDTH+15:16];

    assign alu_a   = WIDTH'(op_a);
    assign alu_b   = WIDTH'(op_b);
    assign alu_fun = fun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_LOAD) begin
                        state_nxt = GET_A;
                    end else if (rx_data == CMD_REPEAT) begin
                        state_nxt = GET_FUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            GET_A, GET_B, GET_FUN: begin
                // A byte arriving in the expiry cycle still counts
                if (rx_valid) begin
                    if (state == GET_A) begin
                        state_nxt = GET_B;
                    end else if (state == GET_B) begin
                        state_nxt = GET_FUN;
                    end else begin
                        state_nxt = EXEC;
                    end
                end else if (timeout) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            EXEC:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = SEND_LO;
            SEND_LO: begin
                if (!tx_busy) begin
                    state_nxt = SEND_HI;
                end
            end
            SEND_HI: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_en   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state)
            EXEC: alu_en = 1'b1;
            SEND_LO: begin
                tx_valid = 1'b1;
                tx_data  = res_ext[7:0];
            end
            SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = res_ext[15:8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= err_nxt;
            if (in_get && !rx_valid && !timeout) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    // Operands are staged and only committed once a CC frame completes,
    // so an aborted frame leaves the previous operands intact for DD reruns.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_stage  <= 8'h00;
            b_stage  <= 8'h00;
            cc_frame <= 1'b0;
            op_a     <= 8'h00;
            op_b     <= 8'h00;
            fun      <= 4'h0;
            alu_ok   <= 1'b0;
            res      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        cc_frame <= (rx_data == CMD_LOAD);
                    end
                end
                GET_A: begin
                    if (rx_valid) begin
                        a_stage <= rx_data;
                    end
                end
                GET_B: begin
                    if (rx_valid) begin
                        b_stage <= rx_data;
                    end
                end
                GET_FUN: begin
                    if (rx_valid) begin
                        fun <= rx_data[3:0];
                        if (cc_frame) begin
                            op_a <= a_stage;
                            op_b <= b_stage;
                        end
                    end
                end
                EXEC:    alu_ok <= alu_valid;
                CAPTURE: res    <= alu_ok ? alu_out : RES_ERR;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Randomized scoreboard bench for alu_cmd_ctrl: stimulus pushes expected ALU commands,
// result bytes and error pulses; a negedge monitor pops and compares.
module tb_alu_cmd_ctrl;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 20;
    localparam logic [7:0] CMD_CC = 8'hCC;
    localparam logic [7:0] CMD_DD = 8'hDD;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_fun;
    logic             alu_en;
    logic [WIDTH-1:0] alu_out = '0;
    logic             alu_valid = 1'b1;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_busy = 1'b0;
    logic             frame_err;

    alu_cmd_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_fun  (alu_fun),
        .alu_en   (alu_en),
        .alu_out  (alu_out),
        .alu_valid(alu_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_busy  (tx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       f;
        int               t;
    } exec_t;

    exec_t      exq[$];
    logic [7:0] txq[$];
    int         startq[$];
    int         errq[$];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int busy_mode = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_b = 8'h00;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [3:0] f);
        logic [WIDTH-1:0] r;
        case (f[1:0])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = a ^ b;
        endcase
        return r ^ {f[3:2], {(WIDTH-2){1'b0}}};
    endfunction

    // Stand-in ALU with a one-cycle registered result
    always @(posedge clk) begin
        if (alu_en) alu_out <= alu_fn(alu_a, alu_b, alu_fun);
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (busy_mode)
                0:       tx_busy = ($urandom_range(0, 2) == 0);
                1:       tx_busy = 1'b1;
                default: tx_busy = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    exec_t      mon_e;
    logic       prev_tv = 1'b0;
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            prev_tv   = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (alu_en) begin
                if (exq.size() == 0) chk("alu_en_unexpected", 32'd1, 32'd0);
                else begin
                    mon_e = exq.pop_front();
                    chk("alu_a", 32'(alu_a), 32'(mon_e.a));
                    chk("alu_b", 32'(alu_b), 32'(mon_e.b));
                    chk("alu_fun", 32'(alu_fun), 32'(mon_e.f));
                    chk("alu_en_cycle", 32'(ncyc), 32'(mon_e.t));
                end
            end
            if (frame_err) begin
                if (errq.size() == 0) chk("frame_err_unexpected", 32'd1, 32'd0);
                else chk("frame_err_cycle", 32'(ncyc), 32'(errq.pop_front()));
            end
            if (prev_pend) chk("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (tx_valid && !prev_tv) begin
                if (startq.size() == 0) chk("tx_start_unexpected", 32'd1, 32'd0);
                else chk("tx_start_cycle", 32'(ncyc), 32'(startq.pop_front()));
            end
            if (tx_valid && !tx_busy) begin
                if (txq.size() == 0) chk("tx_byte_unexpected", 32'd1, 32'd0);
                else chk("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
            end
            prev_tv   = tx_valid;
            prev_pend = tx_valid && tx_busy;
            prev_data = tx_data;
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, output int ts);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        ts = ncyc + 1;
    endtask

    task automatic idle(input int n);
        int t;
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, t);
    endtask

    function automatic int pick_gap(input int g);
        if (g >= 0) return g;
        return ($urandom_range(0, 5) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
    endfunction

    task automatic wait_tx_done();
        int i;
        i = 0;
        while (txq.size() != 0 && i < 300) begin
            @(posedge clk);
            i++;
        end
        if (txq.size() != 0) begin
            chk("tx_drain_timeout", 32'(txq.size()), 32'd0);
            txq.delete();
            exq.delete();
            startq.delete();
        end
    endtask

    task automatic do_reset(input bit cc_on_release, output int ts);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_alu_en", 32'(alu_en), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_fun", 32'(alu_fun), 32'd0);
        exq.delete();
        txq.delete();
        startq.delete();
        errq.delete();
        last_a = 8'h00;
        last_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ts = ncyc + 1;
        if (cc_on_release) begin
            rx_valid = 1'b1;
            rx_data  = CMD_CC;
        end
    endtask

    task automatic send_exec(input bit is_cc, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] fb, input bit v, input int gap,
                             input bit skip_cmd, output int ts);
        logic [7:0] bytes[$];
        exec_t e;
        logic [WIDTH-1:0] r;
        alu_valid = v;
        if (is_cc) bytes = '{CMD_CC, a, b, fb};
        else bytes = '{CMD_DD, fb};
        foreach (bytes[i]) begin
            if (!(i == 0 && skip_cmd)) begin
                if (i > 0) idle(pick_gap(gap));
                drive(1'b1, bytes[i], ts);
            end
        end
        if (is_cc) begin
            last_a = a;
            last_b = b;
        end
        e.a = WIDTH'(last_a);
        e.b = WIDTH'(last_b);
        e.f = fb[3:0];
        e.t = ts + 1;
        r = v ? alu_fn(e.a, e.b, e.f) : 16'hEEEE;
        exq.push_back(e);
        startq.push_back(ts + 3);
        txq.push_back(r[7:0]);
        txq.push_back(r[15:8]);
    endtask

    task automatic exec_frame(input bit is_cc, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] fb, input bit v, input int gap, input int njunk);
        int ts;
        send_exec(is_cc, a, b, fb, v, gap, 1'b0, ts);
        // Bytes in the EXEC/CAPTURE/first SEND_LO cycles must be ignored
        for (int j = 0; j < njunk; j++) drive(1'b1, 8'($urandom), ts);
        drive(1'b0, 8'h00, ts);
        wait_tx_done();
    endtask

    task automatic timeout_frame(input bit is_cc, input int nbytes, input logic [7:0] d);
        int ts;
        drive(1'b1, is_cc ? CMD_CC : CMD_DD, ts);
        for (int i = 1; i < nbytes; i++) begin
            idle(pick_gap(-1));
            drive(1'b1, d, ts);
        end
        errq.push_back(ts + TIMEOUT + 1);
        idle(TIMEOUT + 1);
    endtask

    task automatic bad_byte(input logic [7:0] d);
        int ts;
        drive(1'b1, d, ts);
        errq.push_back(ts + 1);
        idle(1);
    endtask

    initial begin
        int ts;
        int kind;
        logic [7:0] d;

        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_alu_en", 32'(alu_en), 32'd0);
        do_reset(1'b0, ts);

        exec_frame(1'b1, 8'h05, 8'h03, 8'h01, 1'b1, 0, 0);
        chk("hold_alu_a", 32'(alu_a), 32'h5);
        chk("hold_alu_b", 32'(alu_b), 32'h3);
        exec_frame(1'b0, 8'h00, 8'h00, 8'h02, 1'b1, 0, 0);

        bad_byte(8'h7A);

        do_reset(1'b0, ts);
        timeout_frame(1'b1, 2, 8'h05);
        exec_frame(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 0, 0);

        // Boundary: byte lands exactly on the expiry cycle
        exec_frame(1'b1, 8'h21, 8'h07, 8'h12, 1'b1, TIMEOUT - 1, 0);

        // Transmitter stalled: result byte must hold while rx traffic is dropped
        busy_mode = 1;
        send_exec(1'b1, 8'h12, 8'h34, 8'h03, 1'b1, 0, 1'b0, ts);
        drive(1'b1, 8'h7A, ts);
        drive(1'b1, CMD_CC, ts);
        drive(1'b1, CMD_DD, ts);
        for (int j = 0; j < 10; j++) drive(1'b1, 8'($urandom), ts);
        chk("stall_tx_valid", 32'(tx_valid), 32'd1);
        chk("stall_tx_data", 32'(tx_data), 32'h26);
        drive(1'b0, 8'h00, ts);
        busy_mode = 2;
        drive(1'b0, 8'h00, ts);
        busy_mode = 0;
        wait_tx_done();

        exec_frame(1'b1, 8'h40, 8'h09, 8'h05, 1'b0, 0, 0);

        // Reset while the high byte is pending
        busy_mode = 1;
        send_exec(1'b1, 8'h01, 8'h02, 8'h03, 1'b0, 0, 1'b0, ts);
        void'(txq.pop_back());
        drive(1'b0, 8'h00, ts);
        drive(1'b0, 8'h00, ts);
        drive(1'b0, 8'h00, ts);
        busy_mode = 2;
        drive(1'b0, 8'h00, ts);
        busy_mode = 1;
        idle(3);
        chk("lo_sent_before_rst", 32'(txq.size()), 32'd0);
        do_reset(1'b1, ts);
        busy_mode = 0;
        send_exec(1'b1, 8'h0A, 8'h0B, 8'h00, 1'b1, 0, 1'b1, ts);
        drive(1'b0, 8'h00, ts);
        wait_tx_done();

        for (int it = 0; it < 150; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                d = 8'($urandom);
                if (d == CMD_CC || d == CMD_DD) d = 8'h00;
                bad_byte(d);
            end else if (kind == 1) begin
                if ($urandom_range(0, 1) == 1) timeout_frame(1'b1, $urandom_range(1, 3), 8'($urandom));
                else timeout_frame(1'b0, 1, 8'h00);
            end else begin
                exec_frame(kind < 6, 8'($urandom), 8'($urandom), 8'($urandom),
                           $urandom_range(0, 3) != 0, -1, $urandom_range(0, 3));
            end
        end

        idle(5);
        chk("exq_drained", 32'(exq.size()), 32'd0);
        chk("txq_drained", 32'(txq.size()), 32'd0);
        chk("startq_drained", 32'(startq.size()), 32'd0);
        chk("errq_drained", 32'(errq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
